// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: loads host words serially into a ccff chain, with an optional rotate-and-compare verify pass
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 12,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 5
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              verify_en,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  bit_count
);
    localparam int NW   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int BC_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

    state_t                state_q, state_d;
    logic [WORD_W-1:0]     buf_q, buf_d;
    logic [BC_W-1:0]       bc_q, bc_d;
    logic [CNT_W-1:0]      words_q, words_d;
    logic [CNT_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      bit_count_q, bit_count_d;
    logic [CHAIN_LEN-1:0]  shadow_q, shadow_d;
    logic                  vfy_q, vfy_d;
    logic                  err_q, err_d;

    logic [CNT_W-1:0]      rem;
    logic [BC_W-1:0]       bc_load;
    logic [CHAIN_LEN-1:0]  sh_mask;
    logic                  sh_bit, accept, shift;

    // handshake, chain drive and next-state logic
    always_comb begin
        rem       = CNT_W'(CHAIN_LEN) - acc_q;
        bc_load   = (rem > CNT_W'(WORD_W)) ? BC_W'(WORD_W) : BC_W'(rem);
        sh_mask   = CHAIN_LEN'(1) << bit_count_q;
        sh_bit    = |(shadow_q & sh_mask);
        cfg_ready = (state_q == LOAD) && (bc_q <= BC_W'(1)) && (words_q < CNT_W'(NW));
        accept    = cfg_ready && cfg_valid;
        shift     = (state_q == LOAD) && (bc_q != '0);
        ccff_en   = shift || (state_q == VERIFY);
        ccff_head = shift ? buf_q[0] : ((state_q == VERIFY) ? sh_bit : 1'b0);
        busy      = (state_q == LOAD) || (state_q == VERIFY);
        done      = (state_q == DONE);
        error     = err_q;
        bit_count = bit_count_q;
        state_d     = state_q;
        buf_d       = buf_q;
        bc_d        = bc_q;
        words_d     = words_q;
        acc_d       = acc_q;
        bit_count_d = bit_count_q;
        shadow_d    = shadow_q;
        vfy_d       = vfy_q;
        err_d       = err_q;
        if (abort) begin
            state_d     = IDLE;
            buf_d       = '0;
            bc_d        = '0;
            words_d     = '0;
            acc_d       = '0;
            bit_count_d = '0;
            shadow_d    = '0;
            vfy_d       = 1'b0;
            err_d       = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d     = LOAD;
                        vfy_d       = verify_en;
                        buf_d       = '0;
                        bc_d        = '0;
                        words_d     = '0;
                        acc_d       = '0;
                        bit_count_d = '0;
                        err_d       = 1'b0;
                    end
                end
                LOAD: begin
                    if (shift) begin
                        buf_d       = buf_q >> 1;
                        bc_d        = bc_q - 1'b1;
                        shadow_d    = buf_q[0] ? (shadow_q | sh_mask) : (shadow_q & ~sh_mask);
                        bit_count_d = (bit_count_q == LAST && vfy_q) ? '0 : bit_count_q + 1'b1;
                        if (bit_count_q == LAST) state_d = vfy_q ? VERIFY : DONE;
                    end
                    if (accept) begin
                        buf_d   = cfg_data;
                        bc_d    = bc_load;
                        words_d = words_q + 1'b1;
                        acc_d   = acc_q + CNT_W'(bc_load);
                    end
                end
                VERIFY: begin
                    bit_count_d = bit_count_q + 1'b1;
                    if (ccff_tail != sh_bit) err_d = 1'b1;
                    if (bit_count_q == LAST) state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // state and datapath registers
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            bc_q        <= '0;
            words_q     <= '0;
            acc_q       <= '0;
            bit_count_q <= '0;
            shadow_q    <= '0;
            vfy_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            bc_q        <= bc_d;
            words_q     <= words_d;
            acc_q       <= acc_d;
            bit_count_q <= bit_count_d;
            shadow_q    <= shadow_d;
            vfy_q       <= vfy_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed checks of the chain loader against a 12-flop chain model
module tb_ccff_chain_loader;
    logic       prog_clk = 1'b0;
    logic       prog_reset_n = 1'b0;
    logic       start = 1'b0, verify_en = 1'b0, abort = 1'b0, cfg_valid = 1'b0;
    logic [7:0] cfg_data = '0;
    logic       cfg_ready, ccff_head, ccff_tail, ccff_en, busy, done, error;
    logic [4:0] bit_count;
    logic [11:0] chain = '0;
    logic       inv_en = 1'b0;
    int         tests = 0, fails = 0, idle_bad = 0;

    typedef struct {
        logic       stall, vfy, inv;
        logic [7:0] w0, w1;
        logic [11:0] seq, chain;
        int         done_cyc, gaps, n_ver;
        logic       err;
    } vec_t;
    vec_t vecs[5];

    ccff_chain_loader dut (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start),
        .verify_en(verify_en), .abort(abort), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .ccff_head(ccff_head),
        .ccff_tail(ccff_tail), .ccff_en(ccff_en), .busy(busy), .done(done),
        .error(error), .bit_count(bit_count)
    );

    always #5 prog_clk = ~prog_clk;

    // behavioural chain: head enters flop 0, tail is flop 11
    always @(posedge prog_clk) if (ccff_en) chain <= {chain[10:0], ccff_head};
    assign ccff_tail = chain[11] ^ (inv_en && busy && bit_count == 5'd5);

    always @(negedge prog_clk) if (!ccff_en && ccff_head) idle_bad++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input vec_t v);
        int cyc, wi, n_en, n_ver, gaps, done_cyc;
        logic [11:0] seq;
        logic r1, r8;
        @(negedge prog_clk);
        start = 1'b1; verify_en = v.vfy; inv_en = v.inv;
        @(negedge prog_clk);
        start = 1'b0;
        chk("start_err_clear", 32'(error), 32'd0);
        chk("start_done_clear", 32'(done), 32'd0);
        cyc = 0; wi = 0; n_en = 0; n_ver = 0; gaps = 0; done_cyc = -1; seq = '0; r1 = 1'b0; r8 = 1'b0;
        while (cyc < 100 && done_cyc < 0) begin
            if (done) done_cyc = cyc;
            else begin
                if (cyc == 0) chk("ready_c0", 32'(cfg_ready), 32'd1);
                if (cyc == 1) r1 = cfg_ready;
                if (cyc == 8) r8 = cfg_ready;
                if (ccff_en) begin
                    if (n_en < 12) begin seq[n_en] = ccff_head; n_en++; end
                    else n_ver++;
                end else if (n_en > 0 && n_en < 12) gaps++;
                cfg_valid = (wi < 2) && !(v.stall && cyc >= 8 && cyc <= 10);
                cfg_data  = (wi == 0) ? v.w0 : v.w1;
                if (cfg_valid && cfg_ready) wi++;
                @(posedge prog_clk);
                @(negedge prog_clk);
                cyc++;
            end
        end
        cfg_valid = 1'b0;
        chk("done_seen", 32'(done_cyc >= 0), 32'd1);
        chk("done_cycle", 32'(done_cyc), 32'(v.done_cyc));
        chk("ready_c1", 32'(r1), 32'd0);
        chk("ready_bc1", 32'(r8), 32'd1);
        chk("head_seq", 32'(seq), 32'(v.seq));
        chk("stall_gaps", 32'(gaps), 32'(v.gaps));
        chk("verify_len", 32'(n_ver), 32'(v.n_ver));
        chk("error", 32'(error), 32'(v.err));
        chk("chain", 32'(chain), 32'(v.chain));
        chk("bit_count_end", 32'(bit_count), 32'd12);
        chk("en_in_done", 32'(ccff_en), 32'd0);
        inv_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'hA5, 8'h03, 12'h3A5, 12'hA5C, 13, 0, 0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h03, 12'h3A5, 12'hA5C, 16, 3, 0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'hA5, 8'h03, 12'h3A5, 12'hA5C, 25, 0, 12, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 8'hA5, 8'h03, 12'h3A5, 12'hA5C, 25, 0, 12, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 8'h5A, 8'hFC, 12'hC5A, 12'h5A3, 25, 0, 12, 1'b0};

        repeat (2) @(negedge prog_clk);
        chk("reset_outputs", 32'({cfg_ready, ccff_en, ccff_head, busy, done, error, bit_count}), 32'd0);
        prog_reset_n = 1'b1;
        @(negedge prog_clk);
        chk("idle_outputs", 32'({cfg_ready, ccff_en, busy, done, error, bit_count}), 32'd0);

        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0; cfg_valid = 1'b1; cfg_data = 8'hA5;
        n = 0;
        for (int i = 0; i < 20 && n < 5; i++) begin
            @(posedge prog_clk);
            @(negedge prog_clk);
            cfg_valid = 1'b0;
            if (ccff_en) n++;
        end
        @(posedge prog_clk);
        @(negedge prog_clk);
        chk("pre_reset_bc", 32'(bit_count), 32'd5);
        #1 prog_reset_n = 1'b0;
        #1 chk("async_reset", 32'({cfg_ready, ccff_en, ccff_head, busy, done, error, bit_count}), 32'd0);
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        @(negedge prog_clk);

        for (int i = 0; i < 5; i++) do_load(vecs[i]);

        @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0; cfg_valid = 1'b1; cfg_data = 8'hA5;
        n = 0;
        for (int i = 0; i < 20 && n < 7; i++) begin
            @(posedge prog_clk);
            @(negedge prog_clk);
            cfg_valid = 1'b0;
            if (ccff_en) n++;
        end
        chk("before_abort_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0;
        chk("abort_state", 32'({busy, done, ccff_en, error, cfg_ready, bit_count}), 32'd0);

        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        chk("restart_busy", 32'(busy), 32'd1);
        abort = 1'b1; start = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0; start = 1'b0;
        chk("abort_in_load", 32'({busy, done, ccff_en}), 32'd0);
        abort = 1'b1; start = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0; start = 1'b0;
        chk("abort_beats_start", 32'({busy, done, ccff_en}), 32'd0);
        @(negedge prog_clk);
        chk("still_idle", 32'(busy), 32'd0);

        chk("head_zero_when_idle", 32'(idle_bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
